// File: rtl/adder_pkg.sv
// adder_pkg: width helpers and result conversion shared by the adder tree blocks
package adder_pkg;

    function automatic int tree_w(input int bits, input int num);
        return bits + $clog2(num);
    endfunction

    function automatic int acc_w(input int tw, input int acc_len);
        return tw + $clog2(acc_len);
    endfunction

    function automatic bit is_pow2(input int n);
        return n >= 2 && (n & (n - 1)) == 0;
    endfunction

    // Returns {ovf, o}; the caller keeps the low ob bits of o
    function automatic logic [64:0] convert(input logic signed [63:0] t, input int ob,
                                            input bit sat, input bit sgn);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = sgn ? (64'sd1 <<< (ob - 1)) - 64'sd1 : (64'sd1 <<< ob) - 64'sd1;
        lo = sgn ? -(64'sd1 <<< (ob - 1)) : 64'sd0;
        if (t > hi) return {1'b1, sat ? hi : t};
        if (t < lo) return {1'b1, sat ? lo : t};
        return {1'b0, t};
    endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level: one registered level of N/2 pairwise adders, one bit wider than its inputs
module adder_tree_level #(
    parameter int N   = 2,
    parameter int W   = 8,
    parameter bit SGN = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   valid,
    input  logic [N*W-1:0]         d,
    output logic                   qv,
    output logic [N/2*(W+1)-1:0]   q
);

    logic [N/2*(W+1)-1:0] s;

    for (genvar j = 0; j < N / 2; j++) begin : g_add
        logic [W:0] a;
        logic [W:0] b;
        assign a = {SGN & d[(2*j+1)*W-1], d[2*j*W +: W]};
        assign b = {SGN & d[(2*j+2)*W-1], d[(2*j+1)*W +: W]};
        assign s[j*(W+1) +: W+1] = a + b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qv <= 1'b0;
            q  <= '0;
        end else if (en) begin
            qv <= valid;
            q  <= s;
        end
    end

endmodule

// File: rtl/adder_tree_acc.sv
// adder_tree_acc: pipelined NUM-input adder tree with frame accumulator, wrap/saturate output
// and a single global advance that freezes the whole pipe while the consumer stalls.
module adder_tree_acc
    import adder_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int NUM      = 16,
    parameter int ACC_LEN  = 1,
    parameter int OUT_BITS = 8,
    parameter bit SAT      = 0,
    parameter bit SIGNED   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    output logic                 ready,
    input  logic [NUM*BITS-1:0]  i,
    output logic [OUT_BITS-1:0]  o,
    output logic                 ovf,
    output logic                 valid_out,
    input  logic                 ready_out
);

    localparam int LEVELS = $clog2(NUM);
    localparam int TW     = tree_w(BITS, NUM);
    localparam int AW     = acc_w(TW, ACC_LEN);
    localparam int CW     = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;

    if (!is_pow2(NUM)) begin : g_num_chk
        $error("adder_tree_acc: NUM must be a power of 2 and >= 2");
    end
    if (ACC_LEN < 1) begin : g_acc_chk
        $error("adder_tree_acc: ACC_LEN must be >= 1");
    end

    logic          adv;
    logic [TW-1:0] sum;
    logic          sum_v;
    logic [CW-1:0] cnt;
    logic [AW-1:0] acc;
    logic [AW-1:0] sum_x;
    logic [AW-1:0] total;
    logic [63:0]   total_x;
    logic [64:0]   cv;
    logic          last;

    assign adv   = !valid_out || ready_out;
    assign ready = adv;

    // Each level's bus is local to its generate block; the next level reads it hierarchically
    for (genvar k = 0; k < LEVELS; k++) begin : lv
        localparam int NK = NUM >> k;
        localparam int WK = BITS + k;
        logic [NK*WK-1:0]         d;
        logic                     dv;
        logic [NK/2*(WK+1)-1:0]   q;
        logic                     qv;
        if (k == 0) begin : g_in
            assign d  = i;
            assign dv = valid;
        end else begin : g_chain
            assign d  = lv[k-1].q;
            assign dv = lv[k-1].qv;
        end
        adder_tree_level #(.N(NK), .W(WK), .SGN(SIGNED)) u_level (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .valid (dv),
            .d     (d),
            .qv    (qv),
            .q     (q)
        );
    end

    assign sum   = lv[LEVELS-1].q;
    assign sum_v = lv[LEVELS-1].qv;

    always_comb begin
        sum_x   = SIGNED ? AW'($signed(sum)) : AW'(sum);
        total   = (ACC_LEN == 1 || cnt == '0) ? sum_x : acc + sum_x;
        total_x = SIGNED ? 64'($signed(total)) : 64'(total);
        cv      = convert(total_x, OUT_BITS, SAT, SIGNED);
        last    = cnt == CW'(ACC_LEN - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            o         <= '0;
            ovf       <= 1'b0;
            valid_out <= 1'b0;
        end else if (adv) begin
            valid_out <= 1'b0;
            if (sum_v) begin
                if (last) begin
                    o         <= OUT_BITS'(cv[63:0]);
                    ovf       <= cv[64];
                    valid_out <= 1'b1;
                    cnt       <= '0;
                end else begin
                    acc <= total;
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_acc.sv
// tb_adder_tree_acc: directed checks of four adder_tree_acc configurations sharing one stimulus bus
module tb_adder_tree_acc;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         ready_out;
    logic [127:0] i;
    logic [7:0]   o1, o2, o3;
    logic [11:0]  o4;
    logic         ovf1, ovf2, ovf3, ovf4;
    logic         vo1, vo2, vo3, vo4;
    logic         r1, r2, r3, r4;
    int           compared = 0;
    int           mismatched = 0;

    always #5 clk = ~clk;

    adder_tree_acc #(.BITS(8), .NUM(16), .ACC_LEN(1), .OUT_BITS(8), .SAT(0), .SIGNED(0)) d1 (
        .clk(clk), .rst(rst), .valid(valid), .ready(r1), .i(i),
        .o(o1), .ovf(ovf1), .valid_out(vo1), .ready_out(ready_out));
    adder_tree_acc #(.BITS(8), .NUM(16), .ACC_LEN(1), .OUT_BITS(8), .SAT(1), .SIGNED(0)) d2 (
        .clk(clk), .rst(rst), .valid(valid), .ready(r2), .i(i),
        .o(o2), .ovf(ovf2), .valid_out(vo2), .ready_out(ready_out));
    adder_tree_acc #(.BITS(8), .NUM(16), .ACC_LEN(1), .OUT_BITS(8), .SAT(1), .SIGNED(1)) d3 (
        .clk(clk), .rst(rst), .valid(valid), .ready(r3), .i(i),
        .o(o3), .ovf(ovf3), .valid_out(vo3), .ready_out(ready_out));
    adder_tree_acc #(.BITS(8), .NUM(16), .ACC_LEN(4), .OUT_BITS(12), .SAT(0), .SIGNED(0)) d4 (
        .clk(clk), .rst(rst), .valid(valid), .ready(r4), .i(i),
        .o(o4), .ovf(ovf4), .valid_out(vo4), .ready_out(ready_out));

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sum8(input logic [127:0] v);
        int s = 0;
        for (int k = 0; k < 16; k++) s += int'(v[k*8 +: 8]);
        return 8'(s);
    endfunction

    task automatic send_one(input logic [7:0] e, output int n);
        i = {16{e}};
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        n = 1;
        while (!vo1 && n < 12) begin
            cyc();
            n++;
        end
    endtask

    task automatic pulse_rst();
        valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; ready_out = 1'b1; i = '0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        compared++; if (vo1 !== 1'b0) begin mismatched++; $display("FAIL reset_valid_out got=%b exp=0", vo1); end
        compared++; if (o1 !== 8'h00) begin mismatched++; $display("FAIL reset_o got=%h exp=00", o1); end
        compared++; if (ovf1 !== 1'b0) begin mismatched++; $display("FAIL reset_ovf got=%b exp=0", ovf1); end
        compared++; if (r1 !== 1'b1) begin mismatched++; $display("FAIL reset_ready got=%b exp=1", r1); end
        compared++; if (d4.cnt !== 2'd0) begin mismatched++; $display("FAIL reset_cnt got=%0d exp=0", d4.cnt); end
    endtask

    task automatic test_basic();
        int n;
        send_one(8'h01, n);
        compared++; if (n !== 5) begin mismatched++; $display("FAIL latency got=%0d exp=5", n); end
        compared++; if (o1 !== 8'd16) begin mismatched++; $display("FAIL basic_o got=%0d exp=16", o1); end
        compared++; if (ovf1 !== 1'b0) begin mismatched++; $display("FAIL basic_ovf got=%b exp=0", ovf1); end
        cyc();
        compared++; if (vo1 !== 1'b0) begin mismatched++; $display("FAIL basic_single_pulse got=%b exp=0", vo1); end
    endtask

    task automatic test_overflow();
        int n;
        send_one(8'hFF, n);
        compared++; if (o1 !== 8'hF0 || ovf1 !== 1'b1) begin mismatched++; $display("FAIL wrap_ff got=%h/%b exp=f0/1", o1, ovf1); end
        compared++; if (o2 !== 8'hFF || ovf2 !== 1'b1) begin mismatched++; $display("FAIL sat_ff got=%h/%b exp=ff/1", o2, ovf2); end
        compared++; if (o3 !== 8'hF0 || ovf3 !== 1'b0) begin mismatched++; $display("FAIL signed_m1 got=%h/%b exp=f0/0", o3, ovf3); end
        cyc();
    endtask

    task automatic test_signed();
        int n;
        send_one(8'h80, n);
        compared++; if (o3 !== 8'h80 || ovf3 !== 1'b1) begin mismatched++; $display("FAIL signed_min got=%h/%b exp=80/1", o3, ovf3); end
        compared++; if (o1 !== 8'h00 || ovf1 !== 1'b1) begin mismatched++; $display("FAIL wrap_800 got=%h/%b exp=00/1", o1, ovf1); end
        compared++; if (o2 !== 8'hFF || ovf2 !== 1'b1) begin mismatched++; $display("FAIL sat_800 got=%h/%b exp=ff/1", o2, ovf2); end
        cyc();
        send_one(8'h01, n);
        compared++; if (o3 !== 8'h10 || ovf3 !== 1'b0) begin mismatched++; $display("FAIL signed_pos got=%h/%b exp=10/0", o3, ovf3); end
        cyc();
    endtask

    task automatic test_accumulate();
        int pulses = 0;
        logic [11:0] got = '0;
        logic gov = 1'b0;
        pulse_rst();
        valid = 1'b1;
        i = {16{8'd1}}; cyc();
        i = {16{8'd2}}; cyc();
        valid = 1'b0; cyc(); cyc();
        valid = 1'b1;
        i = {16{8'd3}}; cyc();
        i = {16{8'd4}}; cyc();
        valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (vo4) begin pulses++; got = o4; gov = ovf4; end
            cyc();
        end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL acc_pulses got=%0d exp=1", pulses); end
        compared++; if (got !== 12'h0A0 || gov !== 1'b0) begin mismatched++; $display("FAIL acc_sum got=%h/%b exp=0a0/0", got, gov); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [7:0] held = '0;
        logic [7:0] e;
        logic prev_stall = 1'b0;
        int pushed = 0;
        int got = 0;
        for (int c = 0; c < 40; c++) begin
            ready_out = !(c >= 8 && c < 11);
            valid = c < 20;
            for (int k = 0; k < 16; k++) i[k*8 +: 8] = 8'($urandom);
            #1;
            if (vo1 && ready_out) begin
                e = (q.size() > 0) ? q.pop_front() : 8'hxx;
                got++;
                compared++; if (o1 !== e) begin mismatched++; $display("FAIL stream_data got=%h exp=%h idx=%0d", o1, e, got); end
            end
            if (vo1 && !ready_out) begin
                compared++; if (r1 !== 1'b0) begin mismatched++; $display("FAIL stall_ready got=%b exp=0", r1); end
                if (prev_stall) begin
                    compared++; if (o1 !== held) begin mismatched++; $display("FAIL stall_hold got=%h exp=%h", o1, held); end
                end
            end
            prev_stall = vo1 && !ready_out;
            held = o1;
            if (valid && r1) begin q.push_back(sum8(i)); pushed++; end
            cyc();
        end
        ready_out = 1'b1;
        compared++; if (got !== pushed) begin mismatched++; $display("FAIL stream_count got=%0d exp=%0d", got, pushed); end
        compared++; if (pushed !== 17) begin mismatched++; $display("FAIL stream_accepted got=%0d exp=17", pushed); end
    endtask

    task automatic test_reset_midframe();
        int pulses = 0;
        logic [11:0] got = '0;
        pulse_rst();
        valid = 1'b1;
        i = {16{8'd5}}; cyc(); cyc();
        valid = 1'b0;
        repeat (5) cyc();
        compared++; if (d4.cnt !== 2'd2) begin mismatched++; $display("FAIL midframe_cnt got=%0d exp=2", d4.cnt); end
        pulse_rst();
        compared++; if (vo4 !== 1'b0 || d4.cnt !== 2'd0) begin mismatched++; $display("FAIL midframe_reset got=%b/%0d exp=0/0", vo4, d4.cnt); end
        valid = 1'b1;
        i = {16{8'd1}};
        repeat (4) cyc();
        valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (vo4) begin pulses++; got = o4; end
            cyc();
        end
        compared++; if (pulses !== 1) begin mismatched++; $display("FAIL midframe_pulses got=%0d exp=1", pulses); end
        compared++; if (got !== 12'd64) begin mismatched++; $display("FAIL midframe_sum got=%0d exp=64", got); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_signed();
        test_accumulate();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
